// File: rtl/filter_request_serializer.sv
// Four-lane group buffer that issues valid lanes one at a time, in group FIFO order then ascending lane order.
// Present latency is one edge after a push. The consumer stalls via out_ready, and groups arriving while full are dropped and counted.
module filter_request_serializer #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 8,
  parameter int PROG_FULL_FREE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [4*32-1:0]         in_metadata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [27:0]             out_seq,
  output logic [1:0]              out_lane,
  output logic                    full,
  output logic                    prog_full,
  output logic                    empty,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PF_C    = (AW+1)'(PROG_FULL_FREE);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [4*DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [4*32-1:0]         meta_mem [DEPTH];
  logic [3:0]              mask_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    rem_q, rem_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  logic [1:0]    lane;
  logic [3:0]    lane_oh;
  logic [3:0]    rem_left;
  logic [AW-1:0] rd_nxt;
  logic          push, drop, fire, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign prog_full = ((DEPTH_C - count_q) <= PF_C);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign out_valid = !empty;
  assign out_lane  = empty ? 2'd0 : lane;
  assign out_data  = empty ? '0 : data_mem[rd_ptr_q][lane*DATA_WIDTH +: DATA_WIDTH];
  assign out_seq   = empty ? '0 : meta_mem[rd_ptr_q][lane*32+4 +: 28];

  // Presented lane is the lowest remaining lane of the head group.
  always_comb begin
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rem_q[i]) lane = 2'(i);
    end
    lane_oh = 4'b0001 << lane;
  end

  always_comb begin
    push       = (|in_valid) && !full;
    drop       = (|in_valid) && full;
    fire       = out_valid && out_ready;
    rem_left   = rem_q & ~lane_oh;
    pop        = fire && (rem_left == 4'd0);
    rd_nxt     = rd_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rem_d      = rem_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_nxt;

    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // A pop of the only entry hands the head straight to a same-cycle push.
    if (pop) begin
      if (count_q == ONE_C) rem_d = push ? in_valid : 4'd0;
      else                  rem_d = mask_mem[rd_nxt];
    end else if (fire) begin
      rem_d = rem_left;
    end else if (empty && push) begin
      rem_d = in_valid;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      meta_mem[wr_ptr_q] <= in_metadata;
      mask_mem[wr_ptr_q] <= in_valid;
    end
  end

endmodule

// File: tb/tb_filter_request_serializer.sv
// Bench for filter_request_serializer: a fixed vector table, hand-written corner sequences,
// and random traffic, all checked against a group-queue reference model.
module tb_filter_request_serializer;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [127:0]  in_metadata;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [27:0]   out_seq;
  logic [1:0]    out_lane;
  logic          full, prog_full, empty, overflow;
  logic [15:0]   drop_cnt;

  filter_request_serializer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_FULL_FREE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_metadata(in_metadata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_seq(out_seq),
    .out_lane(out_lane), .full(full), .prog_full(prog_full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]          mask;
    logic [3:0][DW-1:0]  d;
    logic [3:0][27:0]    s;
  } grp_t;

  typedef struct {
    logic [3:0]  vld;
    logic [27:0] base;
    logic        rdy;
    logic        ev;
    logic [1:0]  el;
    logic [27:0] es;
    logic        ee;
  } vec_t;

  grp_t       mq[$];
  logic [3:0] m_done;
  int         m_drop;
  logic       m_ovf;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_lane(input logic [3:0] r);
    int ln = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        ln = i;
        break;
      end
    end
    return ln;
  endfunction

  task automatic model_check();
    logic        ev;
    int          ln;
    logic [DW-1:0] ed;
    logic [27:0] es;
    ev = (mq.size() != 0);
    ln = 0; ed = '0; es = '0;
    if (ev) begin
      ln = first_lane(mq[0].mask & ~m_done);
      ed = mq[0].d[ln];
      es = mq[0].s[ln];
    end
    chk("m_out_valid", out_valid, ev);
    chk("m_out_lane", out_lane, 64'(ln));
    chk("m_out_seq", out_seq, es);
    chk("m_out_data", out_data, ed);
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_prog_full", prog_full, (DEPTH - mq.size()) <= 2);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_drop_cnt", drop_cnt, 64'(m_drop));
    chk("m_overflow", overflow, m_ovf);
  endtask

  task automatic model_reset();
    mq.delete();
    m_done = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check at the next negedge.
  task automatic cyc(input logic [3:0] vld, input logic [27:0] base, input logic rdy);
    grp_t g;
    logic full_pre, hold;
    logic [DW-1:0] pd;
    logic [27:0] ps;
    int ln;
    hold = out_valid && !rdy;
    pd = out_data;
    ps = out_seq;
    g.mask = vld;
    for (int i = 0; i < 4; i++) begin
      g.s[i] = 28'(base + 28'(i));
      g.d[i] = {$urandom(), $urandom()};
      in_data[i*DW +: DW]     = g.d[i];
      in_metadata[i*32 +: 32] = {g.s[i], 4'b0001 << i};
    end
    in_valid  = vld;
    out_ready = rdy;
    full_pre  = (mq.size() == DEPTH);
    if (mq.size() != 0 && rdy) begin
      ln = first_lane(mq[0].mask & ~m_done);
      m_done[ln] = 1'b1;
      if (m_done == mq[0].mask) begin
        void'(mq.pop_front());
        m_done = '0;
      end
    end
    if (vld != 4'd0) begin
      if (full_pre) begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end else begin
        mq.push_back(g);
      end
    end
    @(negedge clk);
    model_check();
    if (hold) begin
      chk("stable_data", out_data, pd);
      chk("stable_seq", out_seq, ps);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int n;
    logic [3:0] v;

    rst = 1'b1; in_valid = '0; in_data = '0; in_metadata = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    model_check();
    chk("rst_empty", empty, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prog_full", prog_full, 0);
    rst = 1'b0;

    // vld, base, rdy -> expected out_valid, out_lane, out_seq, empty after the edge
    tbl[0]  = '{4'hF, 1,  1, 1, 0, 1,  0};
    tbl[1]  = '{4'h0, 0,  1, 1, 1, 2,  0};
    tbl[2]  = '{4'h0, 0,  1, 1, 2, 3,  0};
    tbl[3]  = '{4'h0, 0,  1, 1, 3, 4,  0};
    tbl[4]  = '{4'h0, 0,  1, 0, 0, 0,  1};
    tbl[5]  = '{4'hA, 10, 0, 1, 1, 11, 0};
    tbl[6]  = '{4'h0, 0,  0, 1, 1, 11, 0};
    tbl[7]  = '{4'h0, 0,  1, 1, 3, 13, 0};
    tbl[8]  = '{4'h0, 0,  1, 0, 0, 0,  1};
    tbl[9]  = '{4'h1, 20, 0, 1, 0, 20, 0};
    tbl[10] = '{4'h4, 30, 1, 1, 2, 32, 0};
    tbl[11] = '{4'h0, 0,  1, 0, 0, 0,  1};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].vld, tbl[i].base, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_lane", i), out_lane, tbl[i].el);
      chk($sformatf("tbl%0d_seq", i), out_seq, tbl[i].es);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].ee);
    end

    // Fill to DEPTH under back-pressure, overflow once, then drain all 32 lanes.
    for (int k = 0; k < 8; k++) begin
      cyc(4'hF, 28'(k*4), 1'b0);
      if (k == 4) chk("fill5_prog_full", prog_full, 0);
      if (k == 5) chk("fill6_prog_full", prog_full, 1);
      if (k == 6) chk("fill7_full", full, 0);
      if (k == 7) chk("fill8_full", full, 1);
    end
    cyc(4'hF, 28'd100, 1'b0);
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head_seq", out_seq, 0);
    for (int j = 0; j < 32; j++) begin
      chk("drain_seq", out_seq, 64'(j));
      cyc(4'h0, 28'd0, 1'b1);
    end
    chk("drain_empty", empty, 1);

    // Pop and push in the same cycle at full: the push is still dropped.
    for (int k = 0; k < 8; k++) cyc(4'h1, 28'(200 + k), 1'b0);
    chk("full2_full", full, 1);
    cyc(4'hF, 28'd300, 1'b1);
    chk("pp_drop_cnt", drop_cnt, 2);
    chk("pp_full", full, 0);
    chk("pp_head_seq", out_seq, 201);
    repeat (7) cyc(4'h0, 28'd0, 1'b1);
    chk("pp_empty", empty, 1);

    // Random traffic with random back-pressure.
    n = 0;
    while (n < 1000) begin
      v = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (v != 4'd0) n++;
      cyc(v, 28'($urandom()), ($urandom_range(0, 2) != 0));
    end
    repeat (40) cyc(4'h0, 28'd0, 1'b1);
    chk("rand_empty", empty, 1);

    // Asynchronous reset mid-group, then normal restart.
    cyc(4'hF, 28'd500, 1'b0);
    cyc(4'h0, 28'd0, 1'b1);
    cyc(4'h0, 28'd0, 1'b1);
    chk("mid_lane", out_lane, 2);
    #2 rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_empty", empty, 1);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_seq", out_seq, 0);
    chk("arst_out_lane", out_lane, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_full", full, 0);
    chk("arst_prog_full", prog_full, 0);
    model_reset();
    @(negedge clk);
    model_check();
    rst = 1'b0;
    cyc(4'hF, 28'd600, 1'b1);
    chk("restart_lane", out_lane, 0);
    chk("restart_seq", out_seq, 600);
    repeat (4) cyc(4'h0, 28'd0, 1'b1);
    chk("restart_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
